// File: rtl/seq_divider_nbit.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first,
// with a start/done handshake and a divide-by-zero flag.
module seq_divider_nbit #(
  parameter int WIDTH     = 10,
  parameter int DIV_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DIV_WIDTH:0]   part_q, part_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIV_WIDTH:0]   r_shift;
  logic [DIV_WIDTH:0]   r_sub;
  logic                 r_ge;

  // The dividend shifts out of the top of shift_q while quotient bits shift in at the bottom.
  always_comb begin
    r_shift = {part_q[DIV_WIDTH-1:0], shift_q[WIDTH-1]};
    r_ge    = (r_shift >= {1'b0, dvsr_q});
    r_sub   = r_shift - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            shift_d = dividend;
            dvsr_d  = divisor;
            part_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        shift_d = {shift_q[WIDTH-2:0], r_ge};
        part_d  = r_ge ? r_sub : r_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          quot_d  = {shift_q[WIDTH-2:0], r_ge};
          rem_d   = r_ge ? r_sub[DIV_WIDTH-1:0] : r_shift[DIV_WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are decoded from the next state so they come straight out of flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      dvsr_q  <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
